// File: rtl/vram_wr_ctrl_pkg.sv
// Shared display/VRAM constants: address map width, VGA geometry, burst size
// and the write-controller state type.
package vram_wr_ctrl_pkg;

    localparam int unsigned DISP_ADDR_WIDTH     = 24;
    localparam int unsigned VGA_VISIBLE_WIDTH   = 640;
    localparam int unsigned VGA_VISIBLE_HEIGHT  = 480;
    localparam int unsigned BURST_BYTES         = 32'h80;
    localparam int unsigned FRAME_BYTES_DEFAULT = VGA_VISIBLE_WIDTH * VGA_VISIBLE_HEIGHT * 4;

    typedef enum logic [2:0] {
        StIdle,
        StWaitFifo,
        StSetAddr,
        StWriting,
        StResp
    } vram_wr_state_t;

endpackage

// File: rtl/vram_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between the VRAM write master and the interconnect.
interface vram_wr_ctrl_if;

    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
        output AWREADY, WREADY, BRESP, BVALID
    );

endinterface

// File: rtl/vram_wr_ctrl_edge_sync.sv
// Three-flop synchronizer with registered rising-edge pulse; safe for asynchronous inputs.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 3'b000;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], din};
            pulse <= (sync[2:1] == 2'b01);
        end
    end

endmodule

// File: rtl/vram_wr_ctrl.sv
// AXI4 burst write master: copies one frame of pixels from an FWFT FIFO into VRAM,
// one outstanding burst at a time.
module vram_wr_ctrl
    import vram_wr_ctrl_pkg::*;
#(
    parameter int unsigned BURST_LEN   = 32,
    parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
    input  logic                       ACLK,
    input  logic                       ARST,
    vram_wr_ctrl_if.master             axi,
    input  logic                       WR_START,
    input  logic [DISP_ADDR_WIDTH-1:0] WR_ADDR,
    input  logic [31:0]                FIFO_DOUT,
    input  logic                       FIFO_BURST_READY,
    output logic                       FIFO_RD,
    output logic                       WR_BUSY,
    output logic                       WR_DONE,
    output logic                       WR_ERR
);

    localparam int unsigned                  BW        = $clog2(BURST_LEN);
    localparam logic [BW-1:0]                LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [DISP_ADDR_WIDTH-1:0]   ADDR_STEP = DISP_ADDR_WIDTH'(BURST_BYTES);

    vram_wr_state_t             state;
    logic [DISP_ADDR_WIDTH-1:0] addr_cnt;
    logic [DISP_ADDR_WIDTH-1:0] addr_sum;
    logic [BW-1:0]              beat_cnt;
    logic [BW-1:0]              beat_nxt;
    logic                       aw_valid;
    logic                       w_valid;
    logic                       w_last;
    logic                       b_ready;
    logic                       start;
    logic                       frame_done;

    edge_sync u_start_sync (
        .clk   (ACLK),
        .rst   (ARST),
        .din   (WR_START),
        .pulse (start)
    );

    // addr_cnt only moves on the AW handshake, so AWADDR is stable while AWVALID waits.
    assign addr_sum    = WR_ADDR + addr_cnt;
    assign beat_nxt    = beat_cnt + BW'(1);
    assign frame_done  = 32'(addr_cnt) >= FRAME_BYTES;

    assign axi.AWADDR  = 32'(addr_sum);
    assign axi.AWLEN   = 8'(BURST_LEN - 1);
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = aw_valid;
    assign axi.WDATA   = FIFO_DOUT;
    assign axi.WSTRB   = 4'hF;
    assign axi.WLAST   = w_last;
    assign axi.WVALID  = w_valid;
    assign axi.BREADY  = b_ready;
    assign FIFO_RD     = w_valid & axi.WREADY;
    assign WR_BUSY     = (state != StIdle);

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state    <= StIdle;
            addr_cnt <= '0;
            beat_cnt <= '0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            w_last   <= 1'b0;
            b_ready  <= 1'b0;
            WR_DONE  <= 1'b0;
            WR_ERR   <= 1'b0;
        end else begin
            WR_DONE <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StWaitFifo;
                        addr_cnt <= '0;
                        WR_ERR   <= 1'b0;
                    end
                end
                StWaitFifo: begin
                    if (FIFO_BURST_READY) begin
                        state    <= StSetAddr;
                        aw_valid <= 1'b1;
                    end
                end
                StSetAddr: begin
                    beat_cnt <= '0;
                    if (axi.AWREADY) begin
                        state    <= StWriting;
                        aw_valid <= 1'b0;
                        addr_cnt <= addr_cnt + ADDR_STEP;
                        w_valid  <= 1'b1;
                        w_last   <= (LAST_BEAT == '0);
                    end
                end
                StWriting: begin
                    if (axi.WREADY) begin
                        beat_cnt <= beat_nxt;
                        w_last   <= (beat_nxt == LAST_BEAT);
                        if (w_last) begin
                            state   <= StResp;
                            w_valid <= 1'b0;
                            w_last  <= 1'b0;
                            b_ready <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    // Errors are recorded but never abort the frame.
                    if (axi.BVALID) begin
                        b_ready <= 1'b0;
                        if (axi.BRESP != 2'b00) begin
                            WR_ERR <= 1'b1;
                        end
                        if (frame_done) begin
                            state   <= StIdle;
                            WR_DONE <= 1'b1;
                        end else if (FIFO_BURST_READY) begin
                            state    <= StSetAddr;
                            aw_valid <= 1'b1;
                        end else begin
                            state <= StWaitFifo;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_wr_ctrl.sv
// Self-checking bench for vram_wr_ctrl: random slave stalls, counting FIFO model and a
// frame-level reference of expected AW addresses, W data and WLAST positions.
module tb_vram_wr_ctrl;
    import vram_wr_ctrl_pkg::*;

    localparam int unsigned FRAME  = 32'h200;
    localparam int unsigned BLEN   = 32;
    localparam int unsigned NBURST = FRAME / (BLEN * 4);
    localparam int unsigned NBEAT  = FRAME / 4;

    logic                       ACLK = 1'b0;
    logic                       ARST = 1'b1;
    logic                       WR_START = 1'b0;
    logic [DISP_ADDR_WIDTH-1:0] WR_ADDR = '0;
    logic [31:0]                FIFO_DOUT = '0;
    logic                       FIFO_BURST_READY = 1'b1;
    logic                       FIFO_RD, WR_BUSY, WR_DONE, WR_ERR;

    vram_wr_ctrl_if axi ();

    vram_wr_ctrl #(.BURST_LEN(BLEN), .FRAME_BYTES(FRAME)) dut (
        .ACLK             (ACLK),
        .ARST             (ARST),
        .axi              (axi),
        .WR_START         (WR_START),
        .WR_ADDR          (WR_ADDR),
        .FIFO_DOUT        (FIFO_DOUT),
        .FIFO_BURST_READY (FIFO_BURST_READY),
        .FIFO_RD          (FIFO_RD),
        .WR_BUSY          (WR_BUSY),
        .WR_DONE          (WR_DONE),
        .WR_ERR           (WR_ERR)
    );

    initial forever #5 ACLK = ~ACLK;

    int vectors = 0;
    int misc = 0;

    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    bit          l_q[$];
    int          b_cnt, done_cnt, rd_viol, stab_viol, gap_awv, gap_wait;
    bit          aw_hs_f, w_hs_f, wl_hs_f, b_hs_f, rd_f;
    bit          stall_en, gap_en, gap_active, b_pend;
    int          err_burst = -1;
    int          gap_left = 0;
    logic [31:0] fifo_head = '0;

    // Monitor: records handshakes mid-cycle, away from the active edge.
    initial begin
        bit p_aw_stall, p_w_stall, p_wlast;
        logic [31:0] p_awaddr, p_wdata;
        p_aw_stall = 0;
        p_w_stall  = 0;
        forever begin
            @(negedge ACLK);
            aw_hs_f = (axi.AWVALID === 1'b1) && (axi.AWREADY === 1'b1);
            w_hs_f  = (axi.WVALID === 1'b1) && (axi.WREADY === 1'b1);
            wl_hs_f = w_hs_f && (axi.WLAST === 1'b1);
            b_hs_f  = (axi.BVALID === 1'b1) && (axi.BREADY === 1'b1);
            rd_f    = (FIFO_RD === 1'b1);
            if (aw_hs_f) aw_q.push_back(axi.AWADDR);
            if (w_hs_f) begin
                w_q.push_back(axi.WDATA);
                l_q.push_back(axi.WLAST === 1'b1);
            end
            if (b_hs_f) b_cnt++;
            if (WR_DONE === 1'b1) done_cnt++;
            if (rd_f != w_hs_f) rd_viol++;
            if (p_aw_stall && (axi.AWVALID !== 1'b1 || axi.AWADDR !== p_awaddr)) stab_viol++;
            if (p_w_stall && (axi.WVALID !== 1'b1 || axi.WDATA !== p_wdata ||
                              axi.WLAST !== p_wlast)) stab_viol++;
            if (gap_active && axi.AWVALID === 1'b1) gap_awv++;
            if (gap_active && WR_BUSY === 1'b1 && axi.AWVALID === 1'b0 &&
                axi.WVALID === 1'b0 && axi.BREADY === 1'b0) gap_wait++;
            p_aw_stall = (axi.AWVALID === 1'b1) && (axi.AWREADY !== 1'b1);
            p_w_stall  = (axi.WVALID === 1'b1) && (axi.WREADY !== 1'b1);
            p_awaddr   = axi.AWADDR;
            p_wdata    = axi.WDATA;
            p_wlast    = (axi.WLAST === 1'b1);
        end
    end

    // Slave and FIFO models, driven 1 time unit after each active edge.
    initial begin
        axi.AWREADY = 1'b1;
        axi.WREADY  = 1'b1;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
        forever begin
            @(posedge ACLK);
            #1;
            if (rd_f) fifo_head = fifo_head + 1;
            FIFO_DOUT   = fifo_head;
            axi.AWREADY = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            axi.WREADY  = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (gap_en && wl_hs_f && w_q.size() == 2 * BLEN) gap_left = 20;
            if (gap_left > 0) begin
                FIFO_BURST_READY = 1'b0;
                gap_active = 1;
                gap_left--;
            end else begin
                FIFO_BURST_READY = 1'b1;
                gap_active = 0;
            end
            if (ARST) begin
                axi.BVALID = 1'b0;
                b_pend = 0;
            end else begin
                if (b_hs_f) axi.BVALID = 1'b0;
                if (wl_hs_f) b_pend = 1;
                if (b_pend && axi.BVALID !== 1'b1 && (!stall_en || $urandom_range(0, 1) == 1)) begin
                    axi.BVALID = 1'b1;
                    axi.BRESP  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
                    b_pend = 0;
                end
            end
        end
    end

    task automatic prep(input logic [DISP_ADDR_WIDTH-1:0] base, input logic [31:0] d0,
                        input bit stall, input int errb, input bit gap);
        WR_ADDR   = base;
        fifo_head = d0;
        stall_en  = stall;
        err_burst = errb;
        gap_en    = gap;
        aw_q.delete();
        w_q.delete();
        l_q.delete();
        b_cnt = 0; done_cnt = 0; rd_viol = 0; stab_viol = 0; gap_awv = 0; gap_wait = 0;
    endtask

    task automatic pulse_start(input int len);
        @(posedge ACLK);
        #1 WR_START = 1'b1;
        repeat (len) @(posedge ACLK);
        #1 WR_START = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        repeat (3) @(posedge ACLK);
        #1;
        ok = (done_cnt != 0);
    endtask

    // Reference: bursts at base + k*0x80, beats carry d0+i, WLAST on every BLEN-th beat.
    function automatic int frame_errs(input logic [DISP_ADDR_WIDTH-1:0] base, input logic [31:0] d0);
        int e = 0;
        logic [31:0] ea;
        for (int k = 0; k < NBURST; k++) begin
            ea = 32'(base) + 32'(k) * 32'd128;
            if (k < aw_q.size() && aw_q[k] !== ea) e++;
        end
        for (int i = 0; i < NBEAT; i++) begin
            if (i < w_q.size()) begin
                if (w_q[i] !== d0 + 32'(i)) e++;
                if (l_q[i] != ((i % BLEN) == BLEN - 1)) e++;
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        logic [7:0] obs;
        string nm[8] = '{"AWVALID", "WVALID", "WLAST", "BREADY", "FIFO_RD", "WR_BUSY",
                         "WR_DONE", "WR_ERR"};
        ARST = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        obs = {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, FIFO_RD, WR_BUSY, WR_DONE, WR_ERR};
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (obs[7-i] !== 1'b0) begin
                misc++;
                $display("FAIL reset_%s: got %b expected 0", nm[i], obs[7-i]);
            end
        end
        vectors++;
        if ({axi.AWLEN, axi.AWSIZE, axi.AWBURST, axi.WSTRB} !== {8'd31, 3'b010, 2'b01, 4'hF}) begin
            misc++;
            $display("FAIL aw_consts: got len=%0d size=%0d burst=%0d strb=%h expected 31/2/1/f",
                     axi.AWLEN, axi.AWSIZE, axi.AWBURST, axi.WSTRB);
        end
        ARST = 1'b0;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_basic();
        bit ok;
        int e;
        prep(24'h1000, 32'd0, 0, -1, 0);
        @(posedge ACLK);
        #1 WR_START = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        vectors++;
        if (WR_BUSY !== 1'b0) begin
            misc++;
            $display("FAIL start_latency_early: busy=%b expected 0", WR_BUSY);
        end
        @(posedge ACLK);
        #1;
        vectors++;
        if (WR_BUSY !== 1'b1) begin
            misc++;
            $display("FAIL start_latency: busy=%b expected 1", WR_BUSY);
        end
        WR_START = 1'b0;
        wait_done(3000, ok);
        vectors++;
        if (!ok) begin misc++; $display("FAIL basic_done_timeout: done=0 expected 1"); end
        e = frame_errs(24'h1000, 32'd0);
        vectors++;
        if (aw_q.size() != NBURST || w_q.size() != NBEAT || e != 0) begin
            misc++;
            $display("FAIL basic_frame: aw=%0d w=%0d errs=%0d expected %0d/%0d/0",
                     aw_q.size(), w_q.size(), e, NBURST, NBEAT);
        end
        vectors++;
        if (done_cnt != 1 || WR_BUSY !== 1'b0 || WR_ERR !== 1'b0) begin
            misc++;
            $display("FAIL basic_end: done=%0d busy=%b err=%b expected 1/0/0",
                     done_cnt, WR_BUSY, WR_ERR);
        end
    endtask

    task automatic test_stalls();
        bit ok;
        int e;
        logic [DISP_ADDR_WIDTH-1:0] base;
        logic [31:0] d0;
        for (int it = 0; it < 2; it++) begin
            base = DISP_ADDR_WIDTH'($urandom_range(0, 4095) * 128);
            d0   = $urandom;
            prep(base, d0, 1, -1, 0);
            pulse_start(1);
            wait_done(6000, ok);
            e = frame_errs(base, d0);
            vectors++;
            if (!ok || aw_q.size() != NBURST || w_q.size() != NBEAT || e != 0) begin
                misc++;
                $display("FAIL stall_frame: done=%0b aw=%0d w=%0d errs=%0d expected 1/%0d/%0d/0",
                         ok, aw_q.size(), w_q.size(), e, NBURST, NBEAT);
            end
            vectors++;
            if (stab_viol != 0 || rd_viol != 0 || done_cnt != 1) begin
                misc++;
                $display("FAIL stall_rules: unstable=%0d bad_rd=%0d done=%0d expected 0/0/1",
                         stab_viol, rd_viol, done_cnt);
            end
        end
        stall_en = 0;
    endtask

    task automatic test_fifo_gap();
        bit ok;
        int e;
        logic [31:0] a2;
        prep(24'h1000, 32'd0, 0, -1, 1);
        pulse_start(1);
        wait_done(3000, ok);
        e  = frame_errs(24'h1000, 32'd0);
        a2 = (aw_q.size() > 2) ? aw_q[2] : 32'hxxxx_xxxx;
        vectors++;
        if (!ok || e != 0 || a2 !== 32'h1100) begin
            misc++;
            $display("FAIL gap_resume: done=%0b errs=%0d aw2=%h expected 1/0/1100", ok, e, a2);
        end
        vectors++;
        if (gap_awv != 0 || gap_wait < 15) begin
            misc++;
            $display("FAIL gap_wait: awvalid_cycles=%0d wait_cycles=%0d expected 0/>=15",
                     gap_awv, gap_wait);
        end
        gap_en = 0;
    endtask

    task automatic test_error();
        bit ok;
        int n = 0;
        prep(24'h1000, 32'd0, 0, 1, 0);
        pulse_start(1);
        while (b_cnt < 1 && n < 2000) begin @(posedge ACLK); #1; n++; end
        vectors++;
        if (WR_ERR !== 1'b0) begin misc++; $display("FAIL err_early: got %b expected 0", WR_ERR); end
        while (b_cnt < 2 && n < 2000) begin @(posedge ACLK); #1; n++; end
        vectors++;
        if (WR_ERR !== 1'b1) begin misc++; $display("FAIL err_set: got %b expected 1", WR_ERR); end
        wait_done(3000, ok);
        vectors++;
        if (!ok || WR_ERR !== 1'b1 || aw_q.size() != NBURST) begin
            misc++;
            $display("FAIL err_frame: done=%0b err=%b aw=%0d expected 1/1/%0d",
                     ok, WR_ERR, aw_q.size(), NBURST);
        end
        prep(24'h1000, 32'd0, 0, -1, 0);
        pulse_start(1);
        n = 0;
        while (WR_BUSY !== 1'b1 && n < 20) begin @(posedge ACLK); #1; n++; end
        vectors++;
        if (WR_ERR !== 1'b0 || WR_BUSY !== 1'b1) begin
            misc++;
            $display("FAIL err_clear: err=%b busy=%b expected 0/1", WR_ERR, WR_BUSY);
        end
        wait_done(3000, ok);
    endtask

    task automatic test_double_start();
        bit ok;
        int n = 0;
        prep(24'h1000, 32'd0, 0, -1, 0);
        pulse_start(1);
        while (b_cnt < 1 && n < 2000) begin @(posedge ACLK); #1; n++; end
        pulse_start(1);
        wait_done(3000, ok);
        repeat (10) @(posedge ACLK);
        #1;
        vectors++;
        if (!ok || aw_q.size() != NBURST || done_cnt != 1 || WR_BUSY !== 1'b0 ||
            frame_errs(24'h1000, 32'd0) != 0) begin
            misc++;
            $display("FAIL double_start: done=%0d aw=%0d busy=%b expected 1/%0d/0",
                     done_cnt, aw_q.size(), WR_BUSY, NBURST);
        end
    endtask

    task automatic test_arst();
        bit ok;
        int n = 0;
        logic [7:0] obs;
        logic [31:0] a0;
        prep(24'h1000, 32'd0, 0, -1, 0);
        pulse_start(1);
        while (w_q.size() < BLEN + 10 && n < 2000) begin @(posedge ACLK); #1; n++; end
        ARST = 1'b1;
        @(posedge ACLK);
        #1;
        obs = {axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY, FIFO_RD, WR_BUSY, WR_DONE, WR_ERR};
        vectors++;
        if (obs !== 8'h00 || n >= 2000) begin
            misc++;
            $display("FAIL arst_outputs: got %b expected 00000000", obs);
        end
        repeat (2) @(posedge ACLK);
        #1 ARST = 1'b0;
        prep(24'h1000, 32'h5000, 0, -1, 0);
        pulse_start(1);
        wait_done(3000, ok);
        a0 = (aw_q.size() > 0) ? aw_q[0] : 32'hxxxx_xxxx;
        vectors++;
        if (!ok || a0 !== 32'h1000 || aw_q.size() != NBURST ||
            frame_errs(24'h1000, 32'h5000) != 0) begin
            misc++;
            $display("FAIL arst_restart: done=%0b aw0=%h aw=%0d expected 1/1000/%0d",
                     ok, a0, aw_q.size(), NBURST);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_fifo_gap();
        test_error();
        test_double_start();
        test_arst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
